// File: rtl/dp_ram_be.sv
// Single-clock simple dual-port RAM: byte-enabled write port A, registered read port B,
// selectable read-during-write behaviour and an optional zero-fill sequence after reset.
module dp_ram_be #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned RDW_MODE     = 0,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    input  logic                enb,
    input  logic [ADDR_W-1:0]   addrb,
    output logic [DATA_W-1:0]   doutb,
    output logic                busy
);

    localparam int          NumLanes = int'(DATA_W / 8);
    localparam int unsigned Depth    = 1 << ADDR_W;

    typedef enum logic {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   doutb_q, doutb_d;
    logic [DATA_W-1:0]   mem_q [Depth];

    logic                clr_active;
    logic                wr_en;
    logic [DATA_W-1:0]   rd_old;
    logic [DATA_W-1:0]   rd_new;
    logic [DATA_W-1:0]   rd_data;

    // State register: clear FSM and its address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RST != 0) ? StClear : StIdle;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic: walk every address once, then fall back to idle
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == '1) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output/datapath decode: port gating during clear and read-during-write merge
    always_comb begin
        clr_active = (state_q == StClear);
        wr_en      = (state_q == StIdle) && ena;
        rd_old     = mem_q[addrb];
        rd_new     = rd_old;
        if (wr_en && (addra == addrb)) begin
            for (int i = 0; i < NumLanes; i++) begin
                if (wea[i]) begin
                    rd_new[8*i +: 8] = dina[8*i +: 8];
                end
            end
        end
        // Write-first returns the merged word; read-first returns the array contents.
        rd_data = (RDW_MODE != 0) ? rd_new : rd_old;
        doutb_d = doutb_q;
        if (enb) begin
            doutb_d = clr_active ? '0 : rd_data;
        end
    end

    // Memory array: zero-fill while clearing, byte-lane writes while idle, untouched on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_active) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (ena) begin
                for (int i = 0; i < NumLanes; i++) begin
                    if (wea[i]) begin
                        mem_q[addra][8*i +: 8] <= dina[8*i +: 8];
                    end
                end
            end
        end
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            doutb_q <= '0;
        end else begin
            doutb_q <= doutb_d;
        end
    end

    assign doutb = doutb_q;
    assign busy  = clr_active;

endmodule
